// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the ccff chain loader and its readback collector.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    LOAD  = 3'b010,
    SHIFT = 3'b100
  } state_e;

  localparam int unsigned DEF_WORD_W    = 32;
  localparam int unsigned DEF_CHAIN_LEN = 1024;

  function automatic int unsigned bits_left_w(input int unsigned chain_len);
    return $clog2(chain_len + 1);
  endfunction

  function automatic int unsigned wcnt_w(input int unsigned word_w);
    return $clog2(word_w);
  endfunction

  function automatic int unsigned num_words(input int unsigned chain_len, input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  function automatic int unsigned last_bits(input int unsigned chain_len, input int unsigned word_w);
    return chain_len % word_w;
  endfunction

  localparam int unsigned NUM_WORDS = num_words(DEF_CHAIN_LEN, DEF_WORD_W);
  localparam int unsigned LAST_BITS = last_bits(DEF_CHAIN_LEN, DEF_WORD_W);

endpackage

// File: rtl/ccff_rb_collector.sv
// Deserialises bits leaving the chain tail into MSB-first readback words;
// a final partial word is left-aligned with zero fill.
module ccff_rb_collector
  import ccff_loader_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              en_i,
  input  logic              bit_i,
  input  logic              last_i,
  input  logic              clr_i,
  output logic [WORD_W-1:0] rb_data_o,
  output logic              rb_valid_o
);

  localparam int unsigned WC_W = wcnt_w(WORD_W);

  logic [WORD_W-2:0] rb_sreg_q;
  logic [WC_W-1:0]   rb_cnt_q;
  logic [WORD_W-1:0] rb_data_q;
  logic              rb_valid_q;
  logic [WORD_W-1:0] rb_shift_s;
  logic [WC_W-1:0]   rb_pad_s;
  logic [WORD_W-1:0] rb_aligned_s;

  // Pad amount equals the number of bits still missing from a short final word.
  always_comb begin
    rb_shift_s   = {rb_sreg_q, bit_i};
    rb_pad_s     = WC_W'(WORD_W - 1) - rb_cnt_q;
    rb_aligned_s = rb_shift_s << rb_pad_s;
  end

  // Clear wins over capture so an aborted load never emits a word.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      rb_sreg_q  <= '0;
      rb_cnt_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (clr_i) begin
        rb_sreg_q <= '0;
        rb_cnt_q  <= '0;
      end else if (en_i) begin
        if (last_i || (rb_cnt_q == WC_W'(WORD_W - 1))) begin
          rb_data_q  <= rb_aligned_s;
          rb_valid_q <= 1'b1;
          rb_sreg_q  <= '0;
          rb_cnt_q   <= '0;
        end else begin
          rb_sreg_q <= rb_shift_s[WORD_W-2:0];
          rb_cnt_q  <= rb_cnt_q + WC_W'(1);
        end
      end else begin
        rb_cnt_q <= rb_cnt_q;
      end
    end
  end

  assign rb_data_o  = rb_data_q;
  assign rb_valid_o = rb_valid_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Word-to-serial loader for a ccff configuration chain: shifts words MSB-first onto
// ccff_head with a gating enable, and collects ccff_tail back into readback words.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BL_W = bits_left_w(CHAIN_LEN);
  localparam int unsigned WC_W = wcnt_w(WORD_W);

  state_e            state_q;
  logic [WORD_W-1:0] sreg_q;
  logic [WC_W-1:0]   wcnt_q;
  logic [BL_W-1:0]   bits_left_q;
  logic              done_q;

  logic              word_end_s;
  logic              last_bit_s;
  logic [WORD_W-1:0] sreg_shift_s;
  logic              rb_clr_s;
  logic              rb_last_s;

  assign word_end_s   = (wcnt_q == WC_W'(WORD_W - 1));
  assign last_bit_s   = (bits_left_q == BL_W'(1));
  assign sreg_shift_s = {sreg_q[WORD_W-2:0], 1'b0};

  // Every SHIFT edge consumes one chain bit; a word boundary either reloads without a bubble or falls back to LOAD.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      wcnt_q      <= '0;
      bits_left_q <= '0;
      done_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      wcnt_q      <= '0;
      bits_left_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= LOAD;
            bits_left_q <= BL_W'(CHAIN_LEN);
            done_q      <= 1'b0;
          end
        end
        LOAD: begin
          if (word_valid) begin
            sreg_q  <= word_data;
            wcnt_q  <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bits_left_q <= bits_left_q - BL_W'(1);
          if (last_bit_s) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            sreg_q  <= '0;
            wcnt_q  <= '0;
          end else if (word_end_s) begin
            wcnt_q <= '0;
            if (word_valid) begin
              sreg_q <= word_data;
            end else begin
              sreg_q  <= sreg_shift_s;
              state_q <= LOAD;
            end
          end else begin
            sreg_q <= sreg_shift_s;
            wcnt_q <= wcnt_q + WC_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign word_ready = (state_q == LOAD) || ((state_q == SHIFT) && word_end_s && !last_bit_s);
  assign ccff_en    = (state_q == SHIFT);
  assign ccff_head  = sreg_q[WORD_W-1];
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

  assign rb_clr_s  = abort || ((state_q == IDLE) && start);
  assign rb_last_s = (state_q == SHIFT) && last_bit_s;

  ccff_rb_collector #(
    .WORD_W(WORD_W)
  ) u_rb_collector (
    .prog_clk    (prog_clk),
    .prog_reset_n(prog_reset_n),
    .en_i        (ccff_en),
    .bit_i       (ccff_tail),
    .last_i      (rb_last_s),
    .clr_i       (rb_clr_s),
    .rb_data_o   (rb_data),
    .rb_valid_o  (rb_valid)
  );

endmodule
